// File: rtl/ahb_gpio_bridge.sv
// ahb_gpio_bridge: AHB-Lite slave front-end for the GPIO register bank.
// Turns AHB address/data phases into the GPIO's native word-addressed port,
// owning pipelining, read wait states and the bus response.
// Optional feature macro: AHB_GPIO_BRIDGE_ERR_EN. When defined, misaligned
// accesses and HSIZE > 2 get a two-cycle ERROR response and cause no access.
module ahb_gpio_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int READ_WAIT  = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] addrIn,
    output logic [ADDR_WIDTH-1:0] addrOut,
    output logic [3:0]            sizeDecode,
    output logic [31:0]           dataIn,
    input  logic [31:0]           dataOut
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD     = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    accept_s;
    logic                    open_s;
    logic                    bad_s;
    logic                    wr_take_s;
    logic                    rd_take_s;
    logic                    err_take_s;
    logic [ADDR_WIDTH-1:0]   addr_in_r;
    logic [ADDR_WIDTH-1:0]   addr_out_r;
    logic [3:0]              lane_r;
    logic [31:0]             wdata_hold_r;
    logic                    unused_s;

    // Byte-lane mask for a transfer; sizes above a word are treated as a word.
    function automatic logic [3:0] lane_decode(input logic [2:0] size, input logic [1:0] low);
        logic [3:0] lanes;
        case (size)
            3'd0:    lanes = 4'b0001 << low;
            3'd1:    lanes = low[1] ? 4'b1100 : 4'b0011;
            3'd2:    lanes = 4'b1111;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

`ifdef AHB_GPIO_BRIDGE_ERR_EN
    // A transfer the GPIO cannot serve: unaligned halfword/word or oversize.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] low);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = low[0];
            3'd2:    bad = (low != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign bad_s = misaligned(HSIZE, HADDR[1:0]);
`else
    assign bad_s = 1'b0;
`endif

    // Only active transfers with the bus ready start an access.
    assign accept_s = HSEL & HTRANS[1] & HREADY;

    // Upper address bits and HTRANS[0] do not affect this slave.
    assign unused_s = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accept qualification and next-state selection.
    always_comb begin
        open_s       = 1'b0;
        wr_take_s    = 1'b0;
        rd_take_s    = 1'b0;
        err_take_s   = 1'b0;
        state_next_s = state_r;

        // Wait and first error cycles hold the bus, so nothing new starts there.
        case (state_r)
            ST_IDLE, ST_WR, ST_RD, ST_ERR2: open_s = 1'b1;
            default:                        open_s = 1'b0;
        endcase

        if (open_s && accept_s) begin
            if (bad_s) begin
                err_take_s = 1'b1;
            end else if (HWRITE) begin
                wr_take_s = 1'b1;
            end else begin
                rd_take_s = 1'b1;
            end
        end else begin
            err_take_s = 1'b0;
        end

        case (state_r)
            ST_RDWAIT: state_next_s = ST_RD;
            ST_ERR1:   state_next_s = ST_ERR2;
            ST_IDLE, ST_WR, ST_RD, ST_ERR2: begin
                if (err_take_s) begin
                    state_next_s = ST_ERR1;
                end else if (wr_take_s) begin
                    state_next_s = ST_WR;
                end else if (rd_take_s) begin
                    state_next_s = (READ_WAIT != 0) ? ST_RDWAIT : ST_RD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Capture addresses/lanes at accept and remember the last written data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_in_r    <= {ADDR_WIDTH{1'b0}};
            addr_out_r   <= {ADDR_WIDTH{1'b0}};
            lane_r       <= 4'b0000;
            wdata_hold_r <= 32'h0000_0000;
        end else begin
            if (wr_take_s) begin
                addr_in_r <= HADDR[ADDR_WIDTH+1:2];
                lane_r    <= lane_decode(HSIZE, HADDR[1:0]);
            end
            if (rd_take_s) begin
                addr_out_r <= HADDR[ADDR_WIDTH+1:2];
            end
            if (state_r == ST_WR) begin
                wdata_hold_r <= HWDATA;
            end
        end
    end

    // Data-phase outputs: write strobes and read data only in their phase.
    always_comb begin
        sizeDecode = 4'b0000;
        dataIn     = wdata_hold_r;
        HRDATA     = 32'h0000_0000;
        HREADYOUT  = 1'b1;
        case (state_r)
            ST_WR: begin
                sizeDecode = lane_r;
                dataIn     = HWDATA;
            end
            ST_RD:     HRDATA    = dataOut;
            ST_RDWAIT: HREADYOUT = 1'b0;
            ST_ERR1:   HREADYOUT = 1'b0;
            default:   HREADYOUT = 1'b1;
        endcase
    end

`ifdef AHB_GPIO_BRIDGE_ERR_EN
    assign HRESP = (state_r == ST_ERR1) || (state_r == ST_ERR2);
`else
    assign HRESP = 1'b0;
`endif

    assign addrIn  = addr_in_r;
    assign addrOut = addr_out_r;

endmodule

// File: tb/tb_ahb_gpio_bridge.sv
// Bench for ahb_gpio_bridge: two bridges (READ_WAIT 0 and 1) on one bus, each
// with its own GPIO register-bank stand-in, checked every cycle against a
// transaction-level model plus hand-computed directed expectations.
module tb_ahb_gpio_bridge;
    localparam int AW = 8;
`ifdef AHB_GPIO_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;

    logic [31:0]   hrdata    [2];
    logic          hreadyout [2];
    logic          hresp     [2];
    logic [AW-1:0] addr_in   [2];
    logic [AW-1:0] addr_out  [2];
    logic [3:0]    size_dec  [2];
    logic [31:0]   data_in   [2];
    logic [31:0]   data_out  [2];

    logic [31:0] g_mem [2][256];
    logic        mem_init;
    bit          chk_en;
    int          n_chk;
    int          n_fail;

    // Model state: what each bridge has in its data phase right now.
    bit            m_wr_act   [2];
    logic [AW-1:0] m_wr_addr  [2];
    logic [3:0]    m_wr_lanes [2];
    bit            m_rd_wait  [2];
    bit            m_rd_act   [2];
    int            m_err      [2];
    logic [AW-1:0] m_rd_addr  [2];
    logic [31:0]   m_din      [2];
    bit            m_seen     [2];
    logic [31:0]   m_mem      [2][256];

    always #5 clk = ~clk;

    ahb_gpio_bridge #(.ADDR_WIDTH(AW), .READ_WAIT(0)) dut0 (
        .clk(clk), .rstn(rstn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
        .addrIn(addr_in[0]), .addrOut(addr_out[0]), .sizeDecode(size_dec[0]),
        .dataIn(data_in[0]), .dataOut(data_out[0])
    );

    ahb_gpio_bridge #(.ADDR_WIDTH(AW), .READ_WAIT(1)) dut1 (
        .clk(clk), .rstn(rstn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
        .addrIn(addr_in[1]), .addrOut(addr_out[1]), .sizeDecode(size_dec[1]),
        .dataIn(data_in[1]), .dataOut(data_out[1])
    );

    // GPIO stand-ins: combinational read, byte-lane commit at the edge ending a write.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_init) begin
                for (int w = 0; w < 256; w++) g_mem[i][w] <= 32'hA500_0000 | 32'(w);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (size_dec[i][b]) g_mem[i][addr_in[i]][b*8 +: 8] <= data_in[i][b*8 +: 8];
            end
        end
    end
    assign data_out[0] = g_mem[0][addr_out[0]];
    assign data_out[1] = g_mem[1][addr_out[1]];

    // Bus ready is the AND of both slaves' expected ready.
    assign hready = !(m_rd_wait[0] || m_err[0] == 2 || m_rd_wait[1] || m_err[1] == 2);

    // Bytes touched by a transfer: a naturally aligned block of 1, 2 or 4 bytes.
    function automatic logic [3:0] exp_lanes(input logic [2:0] size, input logic [31:0] a);
        int bytes = (size >= 3'd2) ? 4 : (1 << size);
        int first = int'(a[1:0]) - (int'(a[1:0]) % bytes);
        return 4'(((1 << bytes) - 1) << first);
    endfunction

    function automatic bit exp_bad(input logic [2:0] size, input logic [31:0] a);
        int bytes = (size >= 3'd2) ? 4 : (1 << size);
        return ERR_EN && ((size > 3'd2) || ((int'(a[1:0]) % bytes) != 0));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] lanes);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (lanes[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Transaction model: one data phase per bridge, advanced on every edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                m_wr_act[i]   <= 1'b0;
                m_wr_addr[i]  <= '0;
                m_wr_lanes[i] <= 4'h0;
                m_rd_wait[i]  <= 1'b0;
                m_rd_act[i]   <= 1'b0;
                m_err[i]      <= 0;
                m_rd_addr[i]  <= '0;
                m_seen[i]     <= 1'b0;
                if (mem_init)
                    for (int w = 0; w < 256; w++) m_mem[i][w] <= 32'hA500_0000 | 32'(w);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_wr_act[i]) begin
                    m_mem[i][m_wr_addr[i]] <= merge(m_mem[i][m_wr_addr[i]], hwdata, m_wr_lanes[i]);
                    m_din[i] <= hwdata;
                end
                m_wr_act[i]  <= 1'b0;
                m_rd_act[i]  <= 1'b0;
                m_rd_wait[i] <= 1'b0;
                if (m_rd_wait[i]) begin
                    m_rd_act[i] <= 1'b1;
                end else if (m_err[i] == 2) begin
                    m_err[i] <= 1;
                end else begin
                    m_err[i] <= 0;
                    if (hsel && htrans[1] && hready) begin
                        if (exp_bad(hsize, haddr)) begin
                            m_err[i] <= 2;
                        end else if (hwrite) begin
                            m_wr_act[i]   <= 1'b1;
                            m_wr_addr[i]  <= haddr[AW+1:2];
                            m_wr_lanes[i] <= exp_lanes(hsize, haddr);
                            m_seen[i]     <= 1'b1;
                        end else begin
                            m_rd_addr[i] <= haddr[AW+1:2];
                            if (i == 1) m_rd_wait[i] <= 1'b1;
                            else        m_rd_act[i]  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %08h, expected %08h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both bridges against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("HRDATA", i, hrdata[i], m_rd_act[i] ? m_mem[i][m_rd_addr[i]] : 32'h0);
                chk("HREADYOUT", i, 32'(hreadyout[i]), 32'(!(m_rd_wait[i] || m_err[i] == 2)));
                chk("HRESP", i, 32'(hresp[i]), 32'(m_err[i] != 0));
                chk("addrIn", i, 32'(addr_in[i]), 32'(m_wr_addr[i]));
                chk("addrOut", i, 32'(addr_out[i]), 32'(m_rd_addr[i]));
                chk("sizeDecode", i, 32'(size_dec[i]), 32'(m_wr_act[i] ? m_wr_lanes[i] : 4'h0));
                if (m_seen[i]) chk("dataIn", i, data_in[i], m_wr_act[i] ? hwdata : m_din[i]);
            end
        end
    end

    task automatic present(input bit sel, input bit wr, input logic [31:0] a, input logic [2:0] sz);
        hsel   = sel;
        htrans = sel ? 2'b10 : 2'b00;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    // Hold the address phase until an edge with HREADY high, then drive write data.
    task automatic complete(input logic [31:0] wd);
        bit done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = hready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL bus_timeout: HREADY stayed low for 20 cycles at %0t", $time);
        end
        hwdata = wd;
    endtask

    task automatic xfer(input bit sel, input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        present(sel, wr, a, sz);
        complete(wd);
    endtask

    task automatic idle();
        xfer(1'b0, 1'b0, 32'h0, 3'd0, hwdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; chk_en = 1'b0; mem_init = 1'b1; rstn = 1'b0;
        present(1'b0, 1'b0, 32'h0, 3'd0);
        hwdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_HREADYOUT", 0, 32'(hreadyout[0]), 32'd1);
        chk("rst_HRESP", 0, 32'(hresp[0]), 32'd0);
        chk("rst_sizeDecode", 1, 32'(size_dec[1]), 32'd0);
        chk("rst_HRDATA", 0, hrdata[0], 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Word write to 0x08, then read back from the same word.
        xfer(1'b1, 1'b1, 32'h08, 3'd2, 32'h0055_0055); #1;
        chk("wr_addrIn", 0, 32'(addr_in[0]), 32'd2);
        chk("wr_sizeDecode", 0, 32'(size_dec[0]), 32'hF);
        chk("wr_dataIn", 0, data_in[0], 32'h0055_0055);
        xfer(1'b1, 1'b0, 32'h08, 3'd2, 32'h0055_0055); #1;
        chk("rd_addrOut", 0, 32'(addr_out[0]), 32'd2);
        chk("rd_HRDATA", 0, hrdata[0], 32'h0055_0055);
        chk("rd_HREADYOUT", 0, 32'(hreadyout[0]), 32'd1);
        chk("rdwait_HREADYOUT", 1, 32'(hreadyout[1]), 32'd0);

        // Byte write to 0x05 for one cycle, then halfword to 0x06.
        xfer(1'b1, 1'b1, 32'h05, 3'd0, 32'h0000_AB00); #1;
        chk("byte_addrIn", 0, 32'(addr_in[0]), 32'd1);
        chk("byte_sizeDecode", 0, 32'(size_dec[0]), 32'b0010);
        idle(); #1;
        chk("byte_done", 0, 32'(size_dec[0]), 32'd0);
        xfer(1'b1, 1'b1, 32'h06, 3'd1, 32'h1234_0000); #1;
        chk("half_sizeDecode", 0, 32'(size_dec[0]), 32'b1100);
        idle();

        // Back-to-back write then read of 0x04.
        xfer(1'b1, 1'b1, 32'h04, 3'd2, 32'hDEAD_BEEF); #1;
        chk("b2b_sizeDecode", 0, 32'(size_dec[0]), 32'hF);
        xfer(1'b1, 1'b0, 32'h04, 3'd2, 32'hDEAD_BEEF); #1;
        chk("b2b_addrOut", 0, 32'(addr_out[0]), 32'd1);
        chk("b2b_HRDATA", 0, hrdata[0], 32'hDEAD_BEEF);
        chk("b2b_HREADYOUT", 0, 32'(hreadyout[0]), 32'd1);
        idle();

        // READ_WAIT=1 read of 0x0C with a write held off during the wait.
        xfer(1'b1, 1'b0, 32'h0C, 3'd2, 32'h0); #1;
        chk("rw_wait", 1, 32'(hreadyout[1]), 32'd0);
        chk("rw_addrOut", 1, 32'(addr_out[1]), 32'd3);
        present(1'b1, 1'b1, 32'h10, 3'd2);
        @(posedge clk); #1;
        chk("rw_ready", 1, 32'(hreadyout[1]), 32'd1);
        chk("rw_HRDATA", 1, hrdata[1], 32'hA500_0003);
        chk("rw_no_accept", 1, 32'(size_dec[1]), 32'd0);
        chk("rw_addrIn_held", 1, 32'(addr_in[1]), 32'd1);
        complete(32'hCAFE_F00D); #1;
        chk("rw_late_addrIn", 1, 32'(addr_in[1]), 32'd4);
        chk("rw_late_sizeDecode", 1, 32'(size_dec[1]), 32'hF);
        idle();

        // Misaligned word write to 0x02.
        xfer(1'b1, 1'b1, 32'h02, 3'd2, 32'h1122_3344);
        present(1'b0, 1'b0, 32'h0, 3'd0); #1;
        if (ERR_EN) begin
            chk("err1_HREADYOUT", 0, 32'(hreadyout[0]), 32'd0);
            chk("err1_HRESP", 0, 32'(hresp[0]), 32'd1);
            chk("err1_sizeDecode", 0, 32'(size_dec[0]), 32'd0);
            @(posedge clk); #1;
            chk("err2_HREADYOUT", 0, 32'(hreadyout[0]), 32'd1);
            chk("err2_HRESP", 0, 32'(hresp[0]), 32'd1);
        end else begin
            chk("mis_addrIn", 0, 32'(addr_in[0]), 32'd0);
            chk("mis_sizeDecode", 0, 32'(size_dec[0]), 32'hF);
            chk("mis_HRESP", 0, 32'(hresp[0]), 32'd0);
        end
        idle();

        // Byte lanes assembled into word 8, then read back.
        for (int k = 0; k < 4; k++)
            xfer(1'b1, 1'b1, 32'h20 + 32'(k), 3'd0, 32'(k + 1) << (8 * k));
        xfer(1'b1, 1'b0, 32'h20, 3'd2, 32'h0); #1;
        chk("lanes_HRDATA", 0, hrdata[0], 32'h0403_0201);
        idle();
        idle();

        // Reset asserted during the write data phase drops the write.
        xfer(1'b1, 1'b1, 32'h14, 3'd2, 32'hFFFF_FFFF); #1;
        chk("rstwr_sizeDecode", 0, 32'(size_dec[0]), 32'hF);
        present(1'b0, 1'b0, 32'h0, 3'd0);
        #1 rstn = 1'b0;
        #1;
        chk("rstwr_drop0", 0, 32'(size_dec[0]), 32'd0);
        chk("rstwr_drop1", 1, 32'(size_dec[1]), 32'd0);
        chk("rstwr_ready", 0, 32'(hreadyout[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_addrIn", 0, 32'(addr_in[0]), 32'd0);
        chk("post_addrOut", 0, 32'(addr_out[0]), 32'd0);
        chk("post_HRDATA", 0, hrdata[0], 32'd0);
        chk("post_HREADYOUT", 1, 32'(hreadyout[1]), 32'd1);
        xfer(1'b1, 1'b0, 32'h14, 3'd2, 32'h0); #1;
        chk("dropped_HRDATA", 0, hrdata[0], 32'hA500_0005);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
